// File: rtl/line_follow_ctrl.sv
// Line follower: synchronised, debounced 3-bit sensor pattern drives an FSM that steers two PWM wheels.
// Optional node strobe/counter under `NODE_COUNT_EN; default build ties node_pulse/node_count to 0.
module line_follow_ctrl #(
  parameter int PWM_PERIOD      = 1000,
  parameter int DUTY_FAST       = 800,
  parameter int DUTY_SLOW       = 400,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int NODE_HOLD       = 50000,
  parameter int LOST_TIMEOUT    = 5000000
) (
  input  logic       clk_50,
  input  logic       rst_n,
  input  logic [2:0] sensor,
  input  logic       enable,
  output logic       motor_l_pwm,
  output logic       motor_r_pwm,
  output logic       motor_l_dir,
  output logic       motor_r_dir,
  output logic [2:0] state,
  output logic       node_pulse,
  output logic [7:0] node_count
);
  localparam int CW  = $clog2(PWM_PERIOD + 1);
  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW  = $clog2(NODE_HOLD + 1);
  localparam int TW  = $clog2(LOST_TIMEOUT + 1);

  localparam logic [CW-1:0]  PER_LAST  = CW'(PWM_PERIOD - 1);
  localparam logic [CW-1:0]  D_FAST    = CW'((DUTY_FAST >= PWM_PERIOD) ? PWM_PERIOD : DUTY_FAST);
  localparam logic [CW-1:0]  D_SLOW    = CW'((DUTY_SLOW >= PWM_PERIOD) ? PWM_PERIOD : DUTY_SLOW);
  localparam logic [DBW-1:0] DB_N      = DBW'(DEBOUNCE_CYCLES);
  localparam logic [HW-1:0]  HOLD_LAST = HW'(NODE_HOLD - 1);
  localparam logic [TW-1:0]  LOST_LAST = TW'(LOST_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0, FWD = 3'd1, LEFT = 3'd2, RIGHT = 3'd3,
    NODE = 3'd4, SEARCH = 3'd5, STOP = 3'd6
  } state_e;

  logic [2:0]     sync1_q, sync2_q, cand_q, stable_q;
  logic           stable_vld_q;
  logic [DBW-1:0] run_q, run_d;

  // Run length of identical synced samples; stable_q only moves when the run reaches DEBOUNCE_CYCLES.
  always_comb begin
    run_d = DBW'(1);
    if (sync2_q == cand_q) run_d = (run_q == DB_N) ? run_q : run_q + DBW'(1);
  end

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q      <= 3'b000;
      sync2_q      <= 3'b000;
      cand_q       <= 3'b000;
      stable_q     <= 3'b000;
      stable_vld_q <= 1'b0;
      run_q        <= '0;
    end else begin
      sync1_q <= sensor;
      sync2_q <= sync1_q;
      cand_q  <= sync2_q;
      run_q   <= run_d;
      if (run_d == DB_N) begin
        stable_q     <= sync2_q;
        stable_vld_q <= 1'b1;
      end
    end
  end

  function automatic state_e pat_next(input logic [2:0] p, input state_e cur);
    case (p)
      3'b010:         pat_next = FWD;
      3'b110, 3'b100: pat_next = LEFT;
      3'b011, 3'b001: pat_next = RIGHT;
      3'b111:         pat_next = NODE;
      3'b000:         pat_next = SEARCH;
      default:        pat_next = cur;
    endcase
  endfunction

  state_e        state_q, nxt_st;
  logic          last_left_q;
  logic [HW-1:0] hold_q;
  logic [TW-1:0] tmr_q;

  // Until the first pattern is debounced after reset, FWD keeps driving instead of reacting to 000.
  always_comb begin
    nxt_st = state_q;
    if (!enable) nxt_st = IDLE;
    else begin
      case (state_q)
        IDLE:              nxt_st = FWD;
        FWD, LEFT, RIGHT:  nxt_st = stable_vld_q ? pat_next(stable_q, state_q) : state_q;
        NODE:              nxt_st = (hold_q == HOLD_LAST) ? pat_next(stable_q, NODE) : NODE;
        SEARCH: begin
          if (stable_q != 3'b000)      nxt_st = pat_next(stable_q, SEARCH);
          else if (tmr_q == LOST_LAST) nxt_st = STOP;
        end
        STOP:              nxt_st = STOP;
        default:           nxt_st = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_left_q <= 1'b0;
      hold_q      <= '0;
      tmr_q       <= '0;
    end else begin
      state_q <= nxt_st;
      if (nxt_st != state_q) begin
        hold_q <= '0;
        tmr_q  <= '0;
      end else begin
        if (state_q == NODE && hold_q != HOLD_LAST)  hold_q <= hold_q + HW'(1);
        if (state_q == SEARCH && tmr_q != LOST_LAST) tmr_q  <= tmr_q + TW'(1);
      end
      if (nxt_st == LEFT && state_q != LEFT)        last_left_q <= 1'b1;
      else if (nxt_st == RIGHT && state_q != RIGHT) last_left_q <= 1'b0;
    end
  end

  logic [CW-1:0] pwm_cnt_q, duty_l_q, duty_r_q, tgt_l, tgt_r;
  logic          dir_l_q, dir_r_q, tdir_l, tdir_r;

  always_comb begin
    tgt_l  = '0;
    tgt_r  = '0;
    tdir_l = 1'b1;
    tdir_r = 1'b1;
    case (state_q)
      FWD, NODE: begin tgt_l = D_FAST; tgt_r = D_FAST; end
      LEFT:      begin tgt_l = D_SLOW; tgt_r = D_FAST; end
      RIGHT:     begin tgt_l = D_FAST; tgt_r = D_SLOW; end
      SEARCH: begin
        tgt_l  = D_SLOW;
        tgt_r  = D_SLOW;
        tdir_l = !last_left_q;
        tdir_r = last_left_q;
      end
      default: ;
    endcase
  end

  // Wheel settings change only at period boundaries, except disable which cuts drive immediately.
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_q <= '0;
      duty_l_q  <= '0;
      duty_r_q  <= '0;
      dir_l_q   <= 1'b1;
      dir_r_q   <= 1'b1;
    end else begin
      pwm_cnt_q <= (pwm_cnt_q == PER_LAST) ? '0 : pwm_cnt_q + CW'(1);
      if (!enable) begin
        duty_l_q <= '0;
        duty_r_q <= '0;
        dir_l_q  <= 1'b1;
        dir_r_q  <= 1'b1;
      end else if (pwm_cnt_q == PER_LAST) begin
        duty_l_q <= tgt_l;
        duty_r_q <= tgt_r;
        dir_l_q  <= tdir_l;
        dir_r_q  <= tdir_r;
      end
    end
  end

  assign motor_l_pwm = (pwm_cnt_q < duty_l_q);
  assign motor_r_pwm = (pwm_cnt_q < duty_r_q);
  assign motor_l_dir = dir_l_q;
  assign motor_r_dir = dir_r_q;
  assign state       = state_q;

`ifdef NODE_COUNT_EN
  logic       node_pulse_q;
  logic [7:0] node_count_q;
  logic       node_entry;

  assign node_entry = (nxt_st == NODE) && (state_q != NODE);

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      node_pulse_q <= 1'b0;
      node_count_q <= 8'h00;
    end else begin
      node_pulse_q <= node_entry;
      if (node_entry && node_count_q != 8'hFF) node_count_q <= node_count_q + 8'd1;
    end
  end

  assign node_pulse = node_pulse_q;
  assign node_count = node_count_q;
`else
  assign node_pulse = 1'b0;
  assign node_count = 8'h00;
`endif
endmodule

// File: doc/line_follow_ctrl.md
LINE_FOLLOW_CTRL -- requirements
Module: line_follow_ctrl

Interface
REQ-001 Parameter PWM_PERIOD, default 1000: PWM period in clk_50 cycles.
REQ-002 Parameter DUTY_FAST, default 800: high duty count, fast wheel.
REQ-003 Parameter DUTY_SLOW, default 400: high duty count, slow wheel and search pivot.
REQ-004 Parameter DEBOUNCE_CYCLES, default 1000: consecutive identical samples needed to accept a sensor pattern.
REQ-005 Parameter NODE_HOLD, default 50000: cycles of straight drive after node entry.
REQ-006 Parameter LOST_TIMEOUT, default 5000000: cycles in SEARCH before STOP.
REQ-007 clk_50  in  1  system clock; single clock domain.
REQ-008 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-009 sensor  in  3  thresholded line bits from ADC stage; [2]=left, [1]=centre, [0]=right; 1=line.
REQ-010 enable  in  1  1=run, 0=force IDLE.
REQ-011 motor_l_pwm, motor_r_pwm  out  1 each  wheel PWM.
REQ-012 motor_l_dir, motor_r_dir  out  1 each  1=forward, 0=reverse.
REQ-013 state  out  3  current FSM state code.
REQ-014 node_pulse  out  1  one-cycle strobe on node entry (NODE_COUNT_EN only).
REQ-015 node_count  out  8  nodes passed (NODE_COUNT_EN only).

Function
REQ-016 sensor SHALL pass a 2-flop synchroniser before any use.
REQ-017 stable_pat SHALL update to the synced value only after DEBOUNCE_CYCLES consecutive identical synced samples; any change restarts the count.
REQ-018 PWM counter SHALL run 0..PWM_PERIOD-1 and wrap; pwm=1 iff counter<duty; duty 0 gives constant 0; duty>=PWM_PERIOD gives constant 1.
REQ-019 Duty and dir registers SHALL load from the FSM targets only on the cycle the counter wraps to 0; exception per REQ-027.
REQ-020 States/codes: IDLE=0, FWD=1, LEFT=2, RIGHT=3, NODE=4, SEARCH=5, STOP=6.
REQ-021 From FWD/LEFT/RIGHT/SEARCH, stable_pat selects next state: 010->FWD; 110,100->LEFT; 011,001->RIGHT; 111->NODE; 000->SEARCH; 101->hold current state.
REQ-022 Targets: IDLE/STOP L=R=0; FWD L=R=FAST fwd; LEFT L=SLOW,R=FAST fwd; RIGHT L=FAST,R=SLOW fwd.
REQ-023 last_turn SHALL record LEFT or RIGHT on entry to that state; SEARCH pivots toward it at SLOW (last LEFT: L reverse, R forward; last RIGHT: mirror).
REQ-024 SEARCH timer SHALL count from entry; at LOST_TIMEOUT cycles without a non-000 stable_pat, go STOP; STOP exits only via enable=0.
REQ-025 NODE drives L=R=FAST fwd, ignores stable_pat for NODE_HOLD cycles, then applies REQ-021; 111 still present keeps NODE without new pulse or count.
REQ-026 IDLE with enable=1 SHALL go FWD next cycle, then follow REQ-021.
REQ-027 enable=0 in any state SHALL go IDLE next cycle and zero both duty registers that same cycle, bypassing REQ-019.
REQ-028 State transitions occur on the clock edge after stable_pat changes; state output is registered.

Reset
REQ-029 rst_n low SHALL asynchronously set state=IDLE, stable_pat=000, last_turn=RIGHT, all counters and timers 0, pwm outputs 0, dir outputs 1, node_pulse 0, node_count 0.
REQ-030 Reset mid-operation SHALL abort any NODE hold or SEARCH timing; first post-reset pattern requires full debounce.

Configuration
REQ-031 Macro NODE_COUNT_EN defined: node_pulse high one cycle on each non-NODE->NODE transition; node_count increments then, saturating at 255.
REQ-032 NODE_COUNT_EN undefined: node_pulse and node_count tied 0, no counter logic; NODE state behaviour unchanged.

Verification (PWM_PERIOD=10, DUTY_FAST=8, DUTY_SLOW=4, DEBOUNCE_CYCLES=3, NODE_HOLD=20, LOST_TIMEOUT=50)
REQ-033 Reset release, enable=1, sensor=010 -> state 0, 1, 1; after first wrap both pwm 8 high/2 low, dir=1.
REQ-034 sensor 010->110 held 5 cycles, 1-cycle 100 glitch in between ignored -> LEFT 1 cycle after debounce; from next wrap L 4/10, R 8/10.
REQ-035 After LEFT, sensor=000 -> SEARCH, L dir=0 duty 4, R dir=1 duty 4; held 50 cycles -> STOP, pwm 0; enable 0 then 1 -> IDLE then FWD.
REQ-036 sensor=111 (NODE_COUNT_EN) -> one node_pulse, node_count 0->1, 20 cycles straight; still 111 -> no second pulse; 256 node entries -> count stays 255.
REQ-037 enable=0 mid-PWM period in RIGHT -> both pwm 0 on next cycle, state 0; rst_n pulse during NODE -> all outputs at REQ-029 values immediately.
